// File: rtl/lpc_frame_loader.sv
// LPC parameter frame loader: 14-word shadow buffer, frame-boundary swap into active registers, v pacing.
// Optional feature macro: LPC_LOADER_UNDERRUN_STOP_EN (halt playback on underrun instead of repeating a frame).
module lpc_frame_loader #(
  parameter int unsigned FRAME_LEN = 160
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               sample_tick,
  input  logic               in_valid,
  input  logic        [15:0] in_data,
  output logic               in_ready,
  output logic               v,
  output logic               voiced,
  output logic        [15:0] pulserate,
  output logic        [15:0] lpcrate,
  output logic signed [15:0] A0,
  output logic signed [15:0] A1,
  output logic signed [15:0] A2,
  output logic signed [15:0] A3,
  output logic signed [15:0] A4,
  output logic signed [15:0] A5,
  output logic signed [15:0] A6,
  output logic signed [15:0] A7,
  output logic signed [15:0] A8,
  output logic signed [15:0] A9,
  output logic signed [15:0] A10,
  output logic               frame_start,
  output logic               underrun
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [15:0] LAST_SAMPLE = 16'(FRAME_LEN - 1);

  state_t      state;
  logic [3:0]  idx;
  logic        shadow_full;
  logic        boundary_pending;
  logic [15:0] frame_cnt;
  logic        shadow_voiced;
  // Words 1..13 of the frame; the header contributes only its voiced bit.
  logic [15:0] shadow [13];
  logic [15:0] act    [13];
  logic        take;
  logic        do_swap;

  assign take = in_valid && in_ready;

  always_comb begin
    do_swap = 1'b0;
    if (!flush && shadow_full)
      do_swap = (state == IDLE) || boundary_pending;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      idx              <= '0;
      shadow_full      <= 1'b0;
      in_ready         <= 1'b1;
      boundary_pending <= 1'b0;
      frame_cnt        <= '0;
      v                <= 1'b0;
      frame_start      <= 1'b0;
      underrun         <= 1'b0;
      voiced           <= 1'b0;
      shadow_voiced    <= 1'b0;
      for (int unsigned i = 0; i < 13; i++) begin
        shadow[i] <= '0;
        act[i]    <= '0;
      end
    end else if (flush) begin
      state            <= IDLE;
      idx              <= '0;
      shadow_full      <= 1'b0;
      in_ready         <= 1'b1;
      boundary_pending <= 1'b0;
      frame_cnt        <= '0;
      v                <= 1'b0;
      frame_start      <= 1'b0;
      underrun         <= 1'b0;
    end else begin
      v           <= 1'b0;
      frame_start <= 1'b0;

      if (take) begin
        if (idx == 4'd0) shadow_voiced <= in_data[15];
        else             shadow[idx - 4'd1] <= in_data;
        if (idx == 4'd13) begin
          idx         <= '0;
          shadow_full <= 1'b1;
          in_ready    <= 1'b0;
        end else begin
          idx <= idx + 4'd1;
        end
      end

      // A swap only happens while the shadow is full, so it never collides with a load.
      if (do_swap) begin
        voiced <= shadow_voiced;
        for (int unsigned i = 0; i < 13; i++) act[i] <= shadow[i];
        shadow_full <= 1'b0;
        in_ready    <= 1'b1;
        frame_start <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (shadow_full) begin
            state     <= RUN;
            frame_cnt <= '0;
          end
        end
        RUN: begin
          if (boundary_pending) begin
            boundary_pending <= 1'b0;
            if (!shadow_full) begin
              underrun <= 1'b1;
`ifdef LPC_LOADER_UNDERRUN_STOP_EN
              state     <= IDLE;
              frame_cnt <= '0;
`endif
            end
          end else if (sample_tick) begin
            v <= 1'b1;
            if (frame_cnt == LAST_SAMPLE) begin
              frame_cnt        <= '0;
              boundary_pending <= 1'b1;
            end else begin
              frame_cnt <= frame_cnt + 16'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pulserate = act[0];
  assign lpcrate   = act[1];
  assign A0        = act[2];
  assign A1        = act[3];
  assign A2        = act[4];
  assign A3        = act[5];
  assign A4        = act[6];
  assign A5        = act[7];
  assign A6        = act[8];
  assign A7        = act[9];
  assign A8        = act[10];
  assign A9        = act[11];
  assign A10       = act[12];

endmodule

// File: tb/tb_lpc_frame_loader.sv
// Self-checking bench for lpc_frame_loader: frame-level model compared every cycle plus directed literal checks.
module tb_lpc_frame_loader;
  localparam int FL = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        sample_tick = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready, v, voiced, frame_start, underrun;
  logic [15:0] pulserate, lpcrate;
  wire  [15:0] a_w [11];

  lpc_frame_loader #(.FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .flush(flush), .sample_tick(sample_tick),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .v(v),
    .voiced(voiced), .pulserate(pulserate), .lpcrate(lpcrate),
    .A0(a_w[0]), .A1(a_w[1]), .A2(a_w[2]), .A3(a_w[3]), .A4(a_w[4]), .A5(a_w[5]),
    .A6(a_w[6]), .A7(a_w[7]), .A8(a_w[8]), .A9(a_w[9]), .A10(a_w[10]),
    .frame_start(frame_start), .underrun(underrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Frame k word i: header, pulserate, lpcrate, A0..A10.
  function automatic logic [15:0] word_of(input int k, input int i);
    if (i == 0) return (k % 2 == 0) ? (16'h8000 | 16'(k)) : 16'(k);
    if (i == 1) return 16'(80 + k);
    if (i == 2) return 16'(160 + k);
    return 16'(k * 16'h2100 + (i - 2));
  endfunction

  // Model: shadow is a queue of accepted words (full at 14), play position counts samples 1..FL.
  logic [15:0] sh [$];
  logic [15:0] m_act [14];
  bit m_run, m_bp, m_und, m_v, m_fs;
  int m_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh.delete();
      foreach (m_act[i]) m_act[i] = '0;
      m_run = 0; m_bp = 0; m_und = 0; m_v = 0; m_fs = 0; m_cnt = 0;
    end else if (flush) begin
      sh.delete();
      m_run = 0; m_bp = 0; m_und = 0; m_v = 0; m_fs = 0; m_cnt = 0;
    end else begin
      bit full, swap, take;
      full = (sh.size() == 14);
      take = in_valid && !full;
      swap = 0;
      m_v = 0; m_fs = 0;
      if (!m_run) begin
        if (full) begin swap = 1; m_run = 1; m_cnt = 0; end
      end else if (m_bp) begin
        m_bp = 0;
        if (full) swap = 1;
        else begin
          m_und = 1;
`ifdef LPC_LOADER_UNDERRUN_STOP_EN
          m_run = 0; m_cnt = 0;
`endif
        end
      end else if (sample_tick) begin
        m_v = 1;
        m_cnt++;
        if (m_cnt == FL) begin m_cnt = 0; m_bp = 1; end
      end
      if (swap) begin
        foreach (m_act[i]) m_act[i] = sh[i];
        sh.delete();
        m_fs = 1;
      end
      if (take) sh.push_back(in_data);
    end
  end

  always @(negedge clk) begin
    cmp("in_ready", 32'(in_ready), 32'(sh.size() != 14));
    cmp("v", 32'(v), 32'(m_v));
    cmp("frame_start", 32'(frame_start), 32'(m_fs));
    cmp("underrun", 32'(underrun), 32'(m_und));
    cmp("voiced", 32'(voiced), 32'(m_act[0][15]));
    cmp("pulserate", 32'(pulserate), 32'(m_act[1]));
    cmp("lpcrate", 32'(lpcrate), 32'(m_act[2]));
    for (int i = 0; i < 11; i++) cmp($sformatf("A%0d", i), 32'(a_w[i]), 32'(m_act[i + 3]));
  end

  int v_count = 0;
  always @(negedge clk) if (v === 1'b1) v_count++;

  bit tick_en = 0;
  int ticks_sent = 0;
  initial begin
    int tc;
    tc = 0;
    forever begin
      @(posedge clk); #1;
      tc++;
      if (tick_en && tc >= 5) begin sample_tick = 1'b1; tc = 0; ticks_sent++; end
      else sample_tick = 1'b0;
    end
  end

  task automatic send_word(input logic [15:0] w, input bit gaps);
    bit rdy, done;
    if (gaps && $urandom_range(0, 2) == 0) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_data  = w;
    done = 0;
    for (int c = 0; c < 300 && !done; c++) begin
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) done = 1;
    end
    if (!done) cmp("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input int k, input int nwords, input bit gaps, input bit hold);
    for (int i = 0; i < nwords; i++) send_word(word_of(k, i), gaps);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_ticks(input int n);
    int t0;
    t0 = ticks_sent;
    for (int c = 0; c < 40 * n && ticks_sent < t0 + n; c++) begin @(posedge clk); #2; end
    if (ticks_sent < t0 + n) cmp("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int v0;
    cycles(3);
    #1 rst = 1'b1;
    cycles(2);
    cmp("rst_in_ready", 32'(in_ready), 32'd1);
    cmp("rst_voiced", 32'(voiced), 32'd0);
    cmp("rst_A0", 32'(a_w[0]), 32'd0);

    // First frame back-to-back from IDLE.
    send_frame(0, 14, 0, 0);
    cmp("f1_in_ready_low", 32'(in_ready), 32'd0);
    cmp("f1_fs_not_yet", 32'(frame_start), 32'd0);
    cycles(1);
    cmp("f1_frame_start", 32'(frame_start), 32'd1);
    cmp("f1_voiced", 32'(voiced), 32'd1);
    cmp("f1_pulserate", 32'(pulserate), 32'd80);
    cmp("f1_lpcrate", 32'(lpcrate), 32'd160);
    cmp("f1_A10", 32'(a_w[10]), 32'd11);
    cmp("f1_underrun", 32'(underrun), 32'd0);
    cmp("f1_in_ready_back", 32'(in_ready), 32'd1);

    // Preload second frame, then 8 samples: boundary swap, then underrun.
    send_frame(1, 14, 0, 0);
    cmp("f2_preload_full", 32'(in_ready), 32'd0);
    v0 = v_count;
    tick_en = 1;
    wait_ticks(8);
    tick_en = 0;
    cycles(3);
    cmp("v_count_8", 32'(v_count - v0), 32'd8);
    cmp("f2_pulserate", 32'(pulserate), 32'd81);
    cmp("f2_voiced", 32'(voiced), 32'd0);
    cmp("underrun_set", 32'(underrun), 32'd1);
    v0 = v_count;
    tick_en = 1;
    wait_ticks(5);
    cycles(2);
`ifdef LPC_LOADER_UNDERRUN_STOP_EN
    cmp("v_after_underrun", 32'(v_count - v0), 32'd0);
`else
    cmp("v_after_underrun", 32'(v_count - v0), 32'd5);
`endif
    cmp("f2_still_active", 32'(lpcrate), 32'd161);

    // Stalled and continuous streaming across three frames while playing.
    send_frame(3, 14, 1, 1);
    send_frame(4, 14, 1, 1);
    send_frame(5, 14, 1, 0);
    cycles(60);
    cmp("f5_active", 32'(pulserate), 32'd85);
    cmp("f5_A0", 32'(a_w[0]), 32'hA501);
    tick_en = 0;
    cycles(10);

    // Flush after 7 words.
    send_frame(6, 7, 0, 0);
    flush = 1'b1; cycles(1); flush = 1'b0;
    cmp("flush_in_ready", 32'(in_ready), 32'd1);
    cmp("flush_underrun", 32'(underrun), 32'd0);
    cmp("flush_hold_params", 32'(pulserate), 32'd85);

    // Flush mid-RUN.
    send_frame(6, 14, 0, 0);
    cycles(2);
    cmp("f6_pulserate", 32'(pulserate), 32'd86);
    tick_en = 1;
    cycles(12);
    flush = 1'b1; cycles(1); flush = 1'b0;
    v0 = v_count;
    cycles(30);
    cmp("flush_v_silent", 32'(v_count - v0), 32'd0);
    cmp("flush_hold_f6", 32'(a_w[10]), 32'hC60B);
    tick_en = 0;
    cycles(5);

    // Asynchronous reset in the middle of a load.
    send_frame(2, 5, 0, 0);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    cmp("arst_in_ready", 32'(in_ready), 32'd1);
    cmp("arst_pulserate", 32'(pulserate), 32'd0);
    cmp("arst_A0", 32'(a_w[0]), 32'd0);
    cmp("arst_voiced", 32'(voiced), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    cycles(1);
    send_frame(7, 14, 0, 0);
    cycles(1);
    cmp("f7_frame_start", 32'(frame_start), 32'd1);
    cmp("f7_pulserate", 32'(pulserate), 32'd87);
    cmp("f7_A0", 32'(a_w[0]), 32'hE701);
    cmp("f7_voiced", 32'(voiced), 32'd0);
    cycles(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule
